// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, request/response payloads
// and the doubleword address check.
package dmem_pkg;

  localparam int unsigned DWORD_BYTES = 8;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned REQ_ADDR_W  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } dmem_resp_t;

  // Misaligned, or the doubleword would run past the end of memory.
  function automatic logic addr_err(input logic [REQ_ADDR_W-1:0] addr,
                                    input int unsigned           mem_bytes);
    logic [REQ_ADDR_W-1:0] last_ok;
    last_ok = REQ_ADDR_W'(mem_bytes - DWORD_BYTES);
    return (addr[2:0] != 3'b000) || (addr > last_ok);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; the last-grant register starts on input 1 so
// input 0 wins the first conflict.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_c_o
);

  logic last_q;

  always_comb begin
    grant_c_o = 2'b00;
    case (req_i)
      2'b01:   grant_c_o = 2'b01;
      2'b10:   grant_c_o = 2'b10;
      2'b11:   grant_c_o = last_q ? 2'b01 : 2'b10;
      default: grant_c_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance_i && (grant_c_o != 2'b00)) begin
      last_q <= grant_c_o[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-cycle access sequencer for the 64-bit data memory.
// Optional per-port grant and conflict counters when DMEM_ARB_PERF_CNT_EN is defined.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [63:0]       req0_wdata,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [63:0]       resp0_rdata,
  output logic              resp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [63:0]       req1_wdata,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [63:0]       resp1_rdata,
  output logic              resp1_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        arb_req_c;
  logic [1:0]        grant_c;
  logic              accept_c;
  logic              err_c;
  logic              resp_hs_c;
  dmem_req_t         req_sel_c;

  logic              port_q;
  logic              write_q;
  logic              err_q;
  logic              mem_write_q;
  logic              mem_read_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdata_q;
  logic              resp0_valid_q;
  logic              resp1_valid_q;
  dmem_resp_t        resp_q;

  // Arbitration only happens in IDLE; the arbiter never grants an idle port.
  assign arb_req_c = {req1_valid, req0_valid} & {2{state_q == IDLE}};

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (reset_n),
    .req_i     (arb_req_c),
    .advance_i (accept_c),
    .grant_c_o (grant_c)
  );

  always_comb begin
    req_sel_c = '0;
    if (grant_c[1]) begin
      req_sel_c.write = req1_write;
      req_sel_c.addr  = REQ_ADDR_W'(req1_addr);
      req_sel_c.wdata = req1_wdata;
    end else begin
      req_sel_c.write = req0_write;
      req_sel_c.addr  = REQ_ADDR_W'(req0_addr);
      req_sel_c.wdata = req0_wdata;
    end
  end

  assign err_c      = addr_err(req_sel_c.addr, MEM_BYTES);
  assign req0_ready = reset_n && (state_q == IDLE) && grant_c[0];
  assign req1_ready = reset_n && (state_q == IDLE) && grant_c[1];
  assign accept_c   = req0_ready || req1_ready;
  assign resp_hs_c  = (state_q == RESP) && (port_q ? resp1_ready : resp0_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are set at the accept edge so they are high for exactly the ACCESS cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q      <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      if (accept_c) begin
        port_q      <= grant_c[1];
        write_q     <= req_sel_c.write;
        err_q       <= err_c;
        mem_write_q <= req_sel_c.write && !err_c;
        mem_read_q  <= !req_sel_c.write && !err_c;
        if (!err_c) begin
          mem_addr_q  <= ADDR_W'(req_sel_c.addr);
          mem_wdata_q <= req_sel_c.wdata;
        end
      end
    end
  end

  // Response register: loaded at the close of ACCESS, held until the owner consumes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q        <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      resp_q.rdata  <= (err_q || write_q) ? 64'd0 : mem_rdata;
      resp_q.err    <= err_q;
      resp0_valid_q <= !port_q;
      resp1_valid_q <= port_q;
    end else if (resp_hs_c) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end
  end

  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = resp_q.rdata;
  assign resp1_rdata = resp_q.rdata;
  assign resp0_err   = resp_q.err;
  assign resp1_err   = resp_q.err;

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] perf_grant0_q;
  logic [31:0] perf_grant1_q;
  logic [31:0] perf_conflict_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grant0_q   <= '0;
      perf_grant1_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (req0_ready && (perf_grant0_q != 32'hFFFF_FFFF)) begin
        perf_grant0_q <= perf_grant0_q + 32'd1;
      end
      if (req1_ready && (perf_grant1_q != 32'hFFFF_FFFF)) begin
        perf_grant1_q <= perf_grant1_q + 32'd1;
      end
      if ((state_q == IDLE) && req0_valid && req1_valid &&
          (perf_conflict_q != 32'hFFFF_FFFF)) begin
        perf_conflict_q <= perf_conflict_q + 32'd1;
      end
    end
  end

  assign perf_grant0   = perf_grant0_q;
  assign perf_grant1   = perf_grant1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-byte memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req0_valid, req0_ready, req0_write;
  logic [63:0] req0_addr, req0_wdata;
  logic        resp0_valid, resp0_ready, resp0_err;
  logic [63:0] resp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [63:0] req1_addr, req1_wdata;
  logic        resp1_valid, resp1_ready, resp1_err;
  logic [63:0] resp1_rdata;
  logic        mem_write, mem_read;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(64), .ADDR_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_CNT_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  // Behavioural memory with a backdoor load port and strobe-cycle counters.
  logic [63:0] mem [8];
  logic        bd_we = 1'b0;
  logic [2:0]  bd_idx = 3'd0;
  logic [63:0] bd_data = 64'd0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  assign mem_rdata = mem[mem_addr[5:3]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_write) mem[mem_addr[5:3]] <= mem_wdata;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  typedef struct {
    string       name;
    bit          port;
    bit          write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? req1_ready : req0_ready;
  endfunction

  function automatic logic rvalid(input bit p);
    return p ? resp1_valid : resp0_valid;
  endfunction

  function automatic logic [63:0] rdata(input bit p);
    return p ? resp1_rdata : resp0_rdata;
  endfunction

  function automatic logic rerr(input bit p);
    return p ? resp1_err : resp0_err;
  endfunction

  task automatic drive(input bit p, input bit v, input bit w,
                       input logic [63:0] a, input logic [63:0] d);
    if (p) begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic preload(input logic [2:0] idx, input logic [63:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called one time unit after a rising edge with the DUT idle; returns the same way.
  task automatic txn(input string name, input bit p, input bit w, input logic [63:0] a,
                     input logic [63:0] d, input logic [63:0] exp_rd, input bit exp_err);
    int n;
    int wr0;
    int rd0;
    drive(p, 1'b1, w, a, d);
    #1;
    n = 0;
    while (!rdy(p) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, " accept"}, rdy(p), 1);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
    check({name, " access mem_write"}, mem_write, w && !exp_err);
    check({name, " access mem_read"}, mem_read, !w && !exp_err);
    check({name, " access resp_valid"}, rvalid(p), 0);
    if (!exp_err) check({name, " mem_addr"}, mem_addr, a);
    @(posedge clk); #1;
    check({name, " resp_valid"}, rvalid(p), 1);
    check({name, " rdata"}, rdata(p), exp_rd);
    check({name, " err"}, rerr(p), exp_err);
    check({name, " strobes idle"}, {mem_write, mem_read}, 0);
    check({name, " write cycles"}, wr_cnt - wr0, (w && !exp_err) ? 1 : 0);
    check({name, " read cycles"}, rd_cnt - rd0, (!w && !exp_err) ? 1 : 0);
    @(posedge clk); #1;
    check({name, " resp released"}, rvalid(p), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit gp;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    resp0_ready = 1; resp1_ready = 1;

    vt[0] = '{"st8",     1'b0, 1'b1, 64'd8,  64'h0123456789ABCDEF, 64'd0, 1'b0};
    vt[1] = '{"ld8",     1'b0, 1'b0, 64'd8,  64'd0, 64'h0123456789ABCDEF, 1'b0};
    vt[2] = '{"ld5",     1'b1, 1'b0, 64'd5,  64'd0, 64'd0, 1'b1};
    vt[3] = '{"st64",    1'b0, 1'b1, 64'd64, 64'hBAD, 64'd0, 1'b1};
    vt[4] = '{"ld56",    1'b1, 1'b0, 64'd56, 64'd0, 64'hDEADBEEFCAFEF00D, 1'b0};
    vt[5] = '{"st40",    1'b1, 1'b1, 64'd40, 64'hA5A55A5A0F0FF0F0, 64'd0, 1'b0};
    vt[6] = '{"ld40",    1'b0, 1'b0, 64'd40, 64'd0, 64'hA5A55A5A0F0FF0F0, 1'b0};
    vt[7] = '{"ldhigh",  1'b0, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1'b1};
    vt[8] = '{"ld48",    1'b1, 1'b0, 64'd48, 64'd0, 64'h6666, 1'b0};

    #2 reset_n = 1'b0;
    #1;
    check("reset ready", {req0_ready, req1_ready}, 0);
    check("reset resp_valid", {resp0_valid, resp1_valid}, 0);
    check("reset err", {resp0_err, resp1_err}, 0);
    check("reset rdata0", resp0_rdata, 0);
    check("reset rdata1", resp1_rdata, 0);
    check("reset strobes", {mem_write, mem_read}, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
`ifdef DMEM_ARB_PERF_CNT_EN
    check("reset perf", {perf_grant0, perf_grant1}, 0);
    check("reset perf_conflict", perf_conflict, 0);
`endif

    @(posedge clk); #1;
    preload(3'd0, 64'd4);
    preload(3'd1, 64'h1111);
    preload(3'd2, 64'd21);
    preload(3'd3, 64'd9);
    preload(3'd4, 64'h4444);
    preload(3'd5, 64'h5555);
    preload(3'd6, 64'h6666);
    preload(3'd7, 64'hDEADBEEFCAFEF00D);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      txn(vt[i].name, vt[i].port, vt[i].write, vt[i].addr, vt[i].wdata,
          vt[i].exp_rdata, vt[i].exp_err);
    end

    // Both ports valid from reset: grants alternate, port 0 first.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 64'd16, 64'd0);
    for (int g = 0; g < 4; g++) begin
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(posedge clk); #2;
        n++;
      end
      gp = req1_ready;
      check("alt grant port", gp, g % 2);
      check("alt single ready", req0_ready && req1_ready, 0);
      @(posedge clk); #1;
      if (g == 2) drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      @(posedge clk); #1;
      check("alt resp_valid", rvalid(gp), 1);
      check("alt rdata", rdata(gp), gp ? 64'd21 : 64'd4);
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
`ifdef DMEM_ARB_PERF_CNT_EN
    check("perf_conflict", perf_conflict, 3);
    check("perf_grant0", perf_grant0, 2);
    check("perf_grant1", perf_grant1, 2);
`endif

    // Response stall on port 1 blocks port 0.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 64'd16, 64'd0);
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("stall accept1", req1_ready, 1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    resp1_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("stall resp1_valid", resp1_valid, 1);
      check("stall resp1_rdata", resp1_rdata, 64'd21);
      check("stall req0_ready", req0_ready, 0);
      @(posedge clk); #1;
    end
    resp1_ready = 1'b1;
    #1;
    check("stall req0_ready before hs", req0_ready, 0);
    @(posedge clk); #1;
    check("stall resp1 released", resp1_valid, 0);
    check("stall req0 granted", req0_ready, 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("stall resp0_valid", resp0_valid, 1);
    check("stall resp0_rdata", resp0_rdata, 64'd4);
    @(posedge clk); #1;

    // Reset during ACCESS of a store: nothing commits.
    drive(1'b0, 1'b1, 1'b1, 64'd24, 64'hFFFF0000FFFF0000);
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("rst accept", req0_ready, 1);
    @(posedge clk); #1;
    check("rst access mem_write", mem_write, 1);
    reset_n = 1'b0;
    #1;
    check("rst async mem_write", mem_write, 0);
    check("rst async mem_addr", mem_addr, 0);
    check("rst async mem_wdata", mem_wdata, 0);
    check("rst async req0_ready", req0_ready, 0);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("rst no resp", {resp0_valid, resp1_valid}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    txn("post-reset ld24", 1'b0, 1'b0, 64'd24, 64'd0, 64'd9, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the single-ported, byte-addressed 64-bit data memory.
- Port 0 serves the CPU load/store stage. Port 1 serves a debug/DMA loader.
- Accepts one doubleword request at a time and drives the memory's write-enable, read-enable, address and write-data for exactly one cycle.
- Registers the read data and returns it on a valid/ready response channel to the requester that issued it.

Parameters:
- MEM_BYTES, 64, size of the data memory in bytes; must be a multiple of 8.
- ADDR_W, 64, request and memory address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_write  in  1  1 = store, 0 = load.
- req0_addr  in  ADDR_W  byte address.
- req0_wdata  in  64  store data, little-endian.
- resp0_valid  out  1  port 0 response valid.
- resp0_ready  in  1  port 0 response consumed.
- resp0_rdata  out  64  load data; 0 for stores and errors.
- resp0_err  out  1  address misaligned or out of range.
- req1_*, resp1_*: identical set for port 1.
- mem_write  out  1  memory write-enable.
- mem_read  out  1  memory read-enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, combinational from mem_addr.

Behaviour:
- The clock is clk. Reset is asynchronous and active-low on reset_n.
- Reset state: IDLE, last_grant = 1 (port 0 wins first).
- Reset values: every ready, resp_valid, resp_err and mem strobe = 0; every rdata, mem_addr and mem_wdata = 0.
- FSM IDLE:
  - grant = the only valid port.
  - If both ports are valid, grant = the port that is not last_grant.
  - reqX_ready = 1 combinationally for the granted port only.
  - On handshake, latch write/addr/wdata/port and the error flag, update last_grant, and go to ACCESS.
- FSM ACCESS (exactly 1 cycle):
  - If no error: drive mem_addr and mem_wdata, and mem_write = write or mem_read = !write.
  - The store commits at the closing edge. mem_rdata is captured into the response register at the same edge.
  - On error: no strobes, captured data = 0.
  - Go to RESP.
- FSM RESP:
  - respX_valid = 1 for the owning port, held stable until respX_ready.
  - On handshake, go to IDLE. A new grant occurs no earlier than the following cycle.
- Latency: request accept to resp_valid = 2 cycles. Throughput = 1 access per 3 cycles minimum.
- Error: addr[2:0] != 0, or addr > MEM_BYTES-8 (unsigned, full width) → resp_err = 1, memory untouched.
- Strobes are 0 outside ACCESS. mem_addr and mem_wdata hold their last value.
- The non-granted port sees ready = 0 and must hold its request. No request is dropped or reordered.
- Reset mid-operation:
  - Immediate return to IDLE; in-flight request discarded, no response issued.
  - Reset asserted during ACCESS before the edge → store not committed.
- A response-side stall (resp_ready = 0) blocks both ports.

Optional Feature:
- Macro DMEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_grant0 and perf_grant1 (32 bits each), counting accepted requests per port.
  - Adds output perf_conflict (32 bits), counting IDLE cycles with both ports valid.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - DWORD_BYTES = 8;
  - a request struct {write, addr, wdata};
  - a response struct {rdata, err}.
- One sub-module, rr_arbiter2: 2-input round-robin with a last-grant register. It is reusable for an instruction/data arbiter later.

Test Plan:
- Port 0 store addr 8, wdata 0x0123456789ABCDEF, then load addr 8:
  - resp0_valid 2 cycles after each accept;
  - load rdata = 0x0123456789ABCDEF;
  - mem_write high for exactly one cycle.
- Both ports valid from reset, loads at addr 0 and 16 with memory preloaded 4 and 21:
  - port 0 granted first, returns 4;
  - port 1 granted next, returns 21;
  - both ports kept valid → grants alternate 0,1,0,1.
- Load at addr 5, then store at addr 64 (MEM_BYTES = 64):
  - resp_err = 1, rdata = 0;
  - mem_read and mem_write stay 0;
  - subsequent load of addr 56 returns the unchanged value.
- resp1_ready held low 5 cycles while port 0 is valid:
  - resp1_valid and rdata stable;
  - req0_ready stays 0 until the resp1 handshake;
  - port 0 then served.
- reset_n pulsed low during ACCESS of a store to addr 24 (old value 9):
  - outputs return to reset values asynchronously;
  - a later load of addr 24 returns 9.
- With DMEM_ARB_PERF_CNT_EN defined, 3 conflicting cycles and 4 grants split 2/2:
  - perf_conflict = 3;
  - perf_grant0 = 2;
  - perf_grant1 = 2.
